seq_div16by8: RTL and testbench

Sequential 16-by-8 unsigned restoring divider: the inverse partner of the team's 8-bit combinational array multiplier. It takes a 16-bit dividend (typically a product) and an 8-bit divisor, and returns an 8-bit quotient and 8-bit remainder after an 8-cycle shift/subtract loop. It sits alongside the multiplier in the arithmetic library. It uses a start/done handshake so a controller can issue one division at a time.

---
 rtl/seq_div16by8.sv | 181 ++++++++++++++++++
 tb/tb_seq_div16by8.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16by8.sv
// -----------------------------------------------------------------------------
// seq_div16by8
//   Sequential 16-by-8 unsigned restoring divider. Works out one quotient bit
//   per clock, MSB first, over eight RUN cycles. A start/done handshake lets a
//   controller issue one division at a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards any in-flight division
//   start      request, sampled only while busy=0
//   dividend   16-bit unsigned dividend, captured with start
//   divisor    8-bit unsigned divisor, captured with start
//   busy       high from the accepting edge until the edge that leaves DONE
//   done       one-cycle completion pulse
//   err        valid with done: divide-by-zero or quotient overflow
//   quotient   8-bit result, held until the next result is loaded
//   remainder  8-bit result, held until the next result is loaded
//
// Build option
//   SEQDIV_EARLY_ERR_EN  When defined, a divisor of zero or a dividend high
//                        byte >= divisor is flagged as the operands are
//                        captured. One RUN cycle later the block reports
//                        err=1 with quotient=remainder=8'hFF. When undefined,
//                        err is tied low and every division runs all eight
//                        iterations.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; results from the last division are held
//   RUN   | shift/subtract iterations, one quotient bit per cycle
//   DONE  | results valid, done=1 for this single cycle
// -----------------------------------------------------------------------------
module seq_div16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // rem_q holds the partial remainder. shf_q starts as the dividend low byte.
  // Each iteration shifts it left: the next dividend bit leaves at the top and
  // the new quotient bit enters at the bottom. After eight shifts it holds the
  // full quotient.
  logic [7:0]  rem_q;
  logic [7:0]  shf_q;
  logic [7:0]  dvs_q;
  logic [2:0]  cnt_q;

  logic [8:0]  trial;
  logic [7:0]  diff;
  logic        q_bit;
  logic [7:0]  rem_nxt;
  logic        accept;
  logic        last_iter;
  logic        abort;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt_q == 3'd7);

  assign trial   = {rem_q, shf_q[7]};
  assign q_bit   = (trial >= {1'b0, dvs_q});
  // When q_bit is set, trial - divisor is below 256, so the low eight bits of
  // the difference are the exact new remainder.
  assign diff    = trial[7:0] - dvs_q;
  assign rem_nxt = q_bit ? diff : trial[7:0];

`ifdef SEQDIV_EARLY_ERR_EN
  logic err_flag_q;
  logic err_chk;
  logic err_q;

  assign err_chk = (divisor == 8'h00) || (dividend[15:8] >= divisor);

  // The check result is taken from the live inputs at the accepting edge. It
  // is acted on during the first RUN cycle, so the error result appears one
  // edge after acceptance.
  assign abort = (state == RUN) && err_flag_q;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        err_flag_q <= err_chk;
      end
      if (abort) begin
        err_q <= 1'b1;
      end else if ((state == RUN) && last_iter) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort || last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= 8'h00;
      shf_q     <= 8'h00;
      dvs_q     <= 8'h00;
      cnt_q     <= 3'd0;
      quotient  <= 8'h00;
      remainder <= 8'h00;
    end else begin
      if (accept) begin
        rem_q <= dividend[15:8];
        shf_q <= dividend[7:0];
        dvs_q <= divisor;
        cnt_q <= 3'd0;
      end else if (state == RUN) begin
        rem_q <= rem_nxt;
        shf_q <= {shf_q[6:0], q_bit};
        cnt_q <= cnt_q + 3'd1;
      end

      // Results move only on the edge that enters DONE.
      if (abort) begin
        quotient  <= 8'hFF;
        remainder <= 8'hFF;
      end else if ((state == RUN) && last_iter) begin
        quotient  <= {shf_q[6:0], q_bit};
        remainder <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_div16by8.sv
module tb_seq_div16by8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  quotient;
  logic [7:0]  remainder;

  int n_vec;
  int n_err;
  logic [7:0] last_q;
  logic [7:0] last_r;

  typedef struct packed {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
  } vec_t;

  vec_t vecs [9];

  seq_div16by8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one division and check latency, results and the handshake.
  task automatic run_op(input string nm, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee,
                        input int elat);
    int  lat;
    bit  got;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_e0"}, busy, 1);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_quotient"}, quotient, eq);
    chk({nm, "_remainder"}, remainder, er);
    chk({nm, "_err"}, err, ee);
    @(posedge clk);
    #1;
    chk({nm, "_done_fall"}, done, 0);
    chk({nm, "_busy_fall"}, busy, 0);
    chk({nm, "_q_hold"}, quotient, eq);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int lat;
    bit got;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  a;

    n_vec    = 0;
    n_err    = 0;
    start    = 1'b0;
    dividend = 16'h0;
    divisor  = 8'h0;
    rst_n    = 1'b0;
    last_q   = 8'h00;
    last_r   = 8'h00;

    vecs = '{
      '{16'hC350, 8'hC8, 8'hFA, 8'h00},
      '{16'h1234, 8'h56, 8'h36, 8'h10},
      '{16'h00FF, 8'h10, 8'h0F, 8'h0F},
      '{16'h00A5, 8'h01, 8'hA5, 8'h00},
      '{16'h0000, 8'h07, 8'h00, 8'h00},
      '{16'h00FE, 8'hFF, 8'h00, 8'hFE},
      '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE},
      '{16'h0100, 8'h02, 8'h80, 8'h00},
      '{16'h7FFF, 8'h80, 8'hFF, 8'h7F}
    };

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op("table", vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 1'b0, 8);
    end

    // A start pulse during RUN and operand changes after capture are ignored.
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 8'h56;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'h0001;
    divisor  = 8'h01;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'hFFFF;
    divisor  = 8'h00;
    @(posedge clk);
    #1;
    chk("ign_q_hold_e4", quotient, last_q);
    chk("ign_r_hold_e4", remainder, last_r);
    chk("ign_busy_e4", busy, 1);
    chk("ign_done_e4", done, 0);
    lat = 4;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
    end
    chk("ign_done_seen", got, 1);
    chk("ign_latency", lat, 8);
    chk("ign_quotient", quotient, 8'h36);
    chk("ign_remainder", remainder, 8'h10);
    chk("ign_err", err, 0);
    @(posedge clk);
    #1;
    chk("ign_busy_fall", busy, 0);
    chk("ign_done_fall", done, 0);

`ifdef SEQDIV_EARLY_ERR_EN
    run_op("err_div0", 16'h0042, 8'h00, 8'hFF, 8'hFF, 1'b1, 1);
    run_op("err_ovf", 16'h6400, 8'h64, 8'hFF, 8'hFF, 1'b1, 1);
    run_op("err_clear", 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8);
`endif

    // Reset asserted mid-division discards it at once.
    @(negedge clk);
    dividend = 16'hFFFF;
    divisor  = 8'hFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8);

    // Sweep of legal operand pairs, half of them built as 8x8 products.
    for (int k = 0; k < 1000; k++) begin
      dvs = 8'($urandom_range(1, 255));
      if (k % 2 == 0) begin
        a   = 8'($urandom_range(0, 255));
        dvd = 16'(a) * 16'(dvs);
      end else begin
        dvd[15:8] = 8'($urandom_range(0, 32'(dvs) - 1));
        dvd[7:0]  = 8'($urandom_range(0, 255));
      end
      run_op("sweep", dvd, dvs, 8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)), 1'b0, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
